alu_res_station: RTL
====================

Name: alu_res_station

Overview:
- Reservation station on the issue side of the integer ALU; it is the initiator of the alu_word interface.
- Accepts dispatched ALU ops whose operands may still be pending.
- Snoops the CDB to capture operand values as they are broadcast.
- Issues one fully-ready op per cycle to the combinational ALU as a registered alu_word (the load bit is the issue strobe).

Parameters:
DEPTH, 4, number of entries (power of 2, >=2)
TAG_W, 3, ROB/CDB tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  squash all entries (mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  a free entry exists
disp_op  in  3  op_t encoding, passed through
disp_funct3  in  3  funct3
disp_funct7  in  1  funct7 alt bit (sub/sra)
disp_src1_data  in  32  src1 value (valid when disp_src1_rdy)
disp_src1_tag  in  TAG_W  producer tag for src1
disp_src1_rdy  in  1  src1 value present
disp_src2_data  in  32  src2 value or immediate
disp_src2_tag  in  TAG_W  producer tag for src2
disp_src2_rdy  in  1  src2 value present
disp_dest_tag  in  TAG_W  destination tag
cdb_request  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_data  in  32  CDB value
alu_op  out  3  alu_word.op
alu_src1_data  out  32  alu_word.src1_data
alu_src2_data  out  32  alu_word.src2_data
alu_funct3  out  3  alu_word.funct3
alu_funct7  out  1  alu_word.funct7
alu_tag  out  TAG_W  alu_word.tag
alu_load  out  1  alu_word.load, issue strobe

Behaviour:
Reset and flush:
- rst or flush (sync): all entries invalid, alu_load=0, all alu_* data/tag fields=0.
- disp_ready=1 in the cycle after.
- flush overrides a same-cycle dispatch, CDB capture and issue; nothing is kept.

Entry state:
- valid, op, funct3, funct7, dest, and per source: data, tag, rdy.

Dispatch:
- disp_ready = combinational OR of ~valid over all entries (registered state).
- A slot freed by this cycle's issue is not visible until the next cycle.
- Accept on disp_valid && disp_ready.
- Write into the lowest-index invalid entry at the clock edge.
- disp_valid while !disp_ready is ignored; the dispatcher must hold it.

CDB wakeup:
- Each cycle with cdb_request, every valid entry whose srcN has rdy=0 and tag==cdb_tag latches data=cdb_data and sets rdy=1.
- Both sources of one entry may wake on the same broadcast.
- Same-cycle bypass: when a dispatched source has rdy=0 and its tag matches the current broadcast, the entry is written with cdb_data and rdy=1.
- Sources with rdy=1 never change.

Issue:
- Eligible = valid && src1_rdy && src2_rdy, evaluated on registered state at the start of the cycle.
- Select the lowest-index eligible entry.
- At the edge: load alu_* from that entry, set alu_load=1, and clear the entry's valid bit.
- With no eligible entry: alu_load=0 and the alu_* fields hold their previous values.
- Latency: an entry dispatched fully ready issues on the next edge, so alu_load is high 1 cycle after acceptance.
- An entry woken by the CDB in cycle N issues no earlier than edge N+1.
- The ALU never stalls; issue is unconditional.
- An entry may be freed by issue and a different entry allocated at the same edge.

Widths and encodings:
- op, funct3 and funct7 are passed through unmodified.
- The station does no arithmetic.
- Tag compares are full TAG_W equality.

Test Plan:
- rst, then dispatch op=ARITH f3=000 f7=0, src1=5 rdy, src2=7 rdy, dest=2 -> next cycle alu_load=1, alu_src1_data=5, alu_src2_data=7, alu_tag=2; the following cycle alu_load=0.
- Dispatch src1 tag=3 not rdy, src2=1 rdy, dest=4; 2 cycles later cdb_request=1 tag=3 data=0x10 -> alu_load=1 on the edge after the broadcast, src1_data=0x10, tag=4; no issue before that.
- Dispatch with src1 tag=5 not rdy in the same cycle as cdb tag=5 data=0xAB -> entry captures 0xAB and issues next cycle.
- Fill all 4 entries with unready sources (tag=6) -> disp_ready=0, and a 5th disp_valid is not accepted. Broadcast tag=6 -> all wake, issue in index order 0,1,2,3 on consecutive cycles; disp_ready=1 the cycle after the first issue.
- With 2 pending entries, assert flush together with disp_valid and cdb_request matching a pending tag -> no issue on any later cycle, alu_load=0, disp_ready=1, no stale entry wakes on later broadcasts.
- Assert rst while an entry is eligible -> alu_load=0 at the next edge and that entry never issues.

Source files
------------

// File: rtl/alu_res_station.sv
// Reservation station feeding the combinational integer ALU. It holds dispatched ops
// until both operands are present, snooping the CDB, and issues one ready op per cycle.
module alu_res_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [2:0]       disp_op,
  input  logic [2:0]       disp_funct3,
  input  logic             disp_funct7,
  input  logic [31:0]      disp_src1_data,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic             disp_src1_rdy,
  input  logic [31:0]      disp_src2_data,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src2_rdy,
  input  logic [TAG_W-1:0] disp_dest_tag,
  input  logic             cdb_request,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [2:0]       alu_op,
  output logic [31:0]      alu_src1_data,
  output logic [31:0]      alu_src2_data,
  output logic [2:0]       alu_funct3,
  output logic             alu_funct7,
  output logic [TAG_W-1:0] alu_tag,
  output logic             alu_load
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [2:0]       funct3;
    logic             funct7;
    logic [TAG_W-1:0] dest;
    logic [31:0]      src1_data;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_rdy;
    logic [31:0]      src2_data;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_rdy;
  } entry_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      src1_data;
    logic [31:0]      src2_data;
    logic [2:0]       funct3;
    logic             funct7;
    logic [TAG_W-1:0] tag;
    logic             load;
  } alu_word_t;

  entry_t     entries_q [DEPTH];
  entry_t     entries_d [DEPTH];
  entry_t     disp_entry;
  alu_word_t  alu_q, alu_d;

  logic             free_any, issue_any;
  logic [IDX_W-1:0] free_idx, issue_idx;
  logic             disp_accept;

  // Priority pickers: scanning downwards leaves the lowest matching index selected.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    issue_any = 1'b0;
    issue_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (entries_q[i].valid && entries_q[i].src1_rdy && entries_q[i].src2_rdy) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  assign disp_ready  = free_any;
  assign disp_accept = disp_valid && free_any;

  // Incoming entry, with same-cycle bypass of a matching CDB broadcast.
  always_comb begin
    disp_entry           = '0;
    disp_entry.valid     = 1'b1;
    disp_entry.op        = disp_op;
    disp_entry.funct3    = disp_funct3;
    disp_entry.funct7    = disp_funct7;
    disp_entry.dest      = disp_dest_tag;
    disp_entry.src1_data = disp_src1_data;
    disp_entry.src1_tag  = disp_src1_tag;
    disp_entry.src1_rdy  = disp_src1_rdy;
    disp_entry.src2_data = disp_src2_data;
    disp_entry.src2_tag  = disp_src2_tag;
    disp_entry.src2_rdy  = disp_src2_rdy;
    if (cdb_request && !disp_src1_rdy && (disp_src1_tag == cdb_tag)) begin
      disp_entry.src1_data = cdb_data;
      disp_entry.src1_rdy  = 1'b1;
    end
    if (cdb_request && !disp_src2_rdy && (disp_src2_tag == cdb_tag)) begin
      disp_entry.src2_data = cdb_data;
      disp_entry.src2_rdy  = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (cdb_request && entries_q[i].valid) begin
        if (!entries_q[i].src1_rdy && (entries_q[i].src1_tag == cdb_tag)) begin
          entries_d[i].src1_data = cdb_data;
          entries_d[i].src1_rdy  = 1'b1;
        end
        if (!entries_q[i].src2_rdy && (entries_q[i].src2_tag == cdb_tag)) begin
          entries_d[i].src2_data = cdb_data;
          entries_d[i].src2_rdy  = 1'b1;
        end
      end
    end
    // Issue slot is always valid and the allocation slot always invalid, so they never collide.
    if (issue_any) entries_d[issue_idx].valid = 1'b0;
    if (disp_accept) entries_d[free_idx] = disp_entry;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    alu_d      = alu_q;
    alu_d.load = 1'b0;
    if (issue_any) begin
      alu_d.op        = entries_q[issue_idx].op;
      alu_d.src1_data = entries_q[issue_idx].src1_data;
      alu_d.src2_data = entries_q[issue_idx].src2_data;
      alu_d.funct3    = entries_q[issue_idx].funct3;
      alu_d.funct7    = entries_q[issue_idx].funct7;
      alu_d.tag       = entries_q[issue_idx].dest;
      alu_d.load      = 1'b1;
    end
    if (flush) alu_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: only the valid bits are reset; payload is never read while its entry is invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) alu_q <= '0;
    else     alu_q <= alu_d;
  end

  assign alu_op        = alu_q.op;
  assign alu_src1_data = alu_q.src1_data;
  assign alu_src2_data = alu_q.src2_data;
  assign alu_funct3    = alu_q.funct3;
  assign alu_funct7    = alu_q.funct7;
  assign alu_tag       = alu_q.tag;
  assign alu_load      = alu_q.load;

endmodule
